// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer
// Avalon-MM initiator that services an edge-capture PIO slave without software:
// programs the irq mask once after reset, then on every irq reads the edge
// capture register, clears it, and queues the captured vector in a small
// first-word-fall-through FIFO for a valid/ready consumer.
module pio_irq_servicer #(
  parameter int unsigned WIDTH      = 4,
  parameter logic [1:0]  ADDR_MASK  = 2'd2,
  parameter logic [1:0]  ADDR_EDGE  = 2'd3,
  parameter logic [31:0] INIT_MASK  = 32'h0000_000F,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [63:0] ONE64 = 64'd1;
  // Mask value trimmed to WIDTH bits and zero-extended onto the 32-bit bus
  localparam logic [31:0] WMASK    = 32'((ONE64 << WIDTH) - 64'd1);
  localparam logic [31:0] MASK_VAL = INIT_MASK & WMASK;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_PUSH    = 3'd5,
    ST_HOLDOFF = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        address_r, address_s;
  logic              chipselect_r, chipselect_s;
  logic              write_n_r, write_n_s;
  logic [31:0]       writedata_r, writedata_s;
  logic [WIDTH-1:0]  cap_r;

  logic [WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]     rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]     count_r, count_s;
  logic [WIDTH-1:0]  evt_data_r, head_s;
  logic              evt_valid_r;
  logic              overflow_r, overflow_s;
  logic              push_req_s, push_ok_s, pop_s, full_s, drop_s;

  assign m_address    = address_r;
  assign m_chipselect = chipselect_r;
  assign m_write_n    = write_n_r;
  assign m_writedata  = writedata_r;
  assign evt_valid    = evt_valid_r;
  assign evt_data     = evt_data_r;
  assign overflow     = overflow_r;

  // Next-state logic; INIT stays put until its single mask write has been on the bus
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT:    if (chipselect_r) state_s = ST_IDLE;    else state_s = ST_INIT;
      ST_IDLE:    if (irq)          state_s = ST_READ;    else state_s = ST_IDLE;
      ST_READ:    state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_CLEAR;
      ST_CLEAR:   state_s = ST_PUSH;
      ST_PUSH:    state_s = ST_HOLDOFF;
      ST_HOLDOFF: state_s = ST_IDLE;
      default:    state_s = ST_INIT;
    endcase
  end

  // Bus decode from the next state so the registered outputs line up with the state they belong to
  always_comb begin
    chipselect_s = 1'b0;
    write_n_s    = 1'b1;
    address_s    = 2'd0;
    writedata_s  = 32'd0;
    case (state_s)
      ST_INIT: begin
        chipselect_s = 1'b1;
        write_n_s    = 1'b0;
        address_s    = ADDR_MASK;
        writedata_s  = MASK_VAL;
      end
      ST_READ: begin
        chipselect_s = 1'b1;
        address_s    = ADDR_EDGE;
      end
      ST_CLEAR: begin
        chipselect_s = 1'b1;
        write_n_s    = 1'b0;
        address_s    = ADDR_EDGE;
      end
      default: begin
        chipselect_s = 1'b0;
      end
    endcase
  end

  // State and bus output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_INIT;
      chipselect_r <= 1'b0;
      write_n_r    <= 1'b1;
      address_r    <= 2'd0;
      writedata_r  <= 32'd0;
    end else begin
      state_r      <= state_s;
      chipselect_r <= chipselect_s;
      write_n_r    <= write_n_s;
      address_r    <= address_s;
      writedata_r  <= writedata_s;
    end
  end

  // Capture the edge vector one cycle after the read (slave readdata is registered)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r <= '0;
    end else if (state_r == ST_CAPTURE) begin
      cap_r <= m_readdata[WIDTH-1:0];
    end else begin
      cap_r <= cap_r;
    end
  end

  // FIFO control: push/pop qualification, pointer/count update and next head value
  always_comb begin
    push_req_s = (state_r == ST_PUSH) && (cap_r != '0);
    pop_s      = evt_valid_r && evt_ready;
    full_s     = (count_r == CW'(FIFO_DEPTH));
    push_ok_s  = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;

    if (push_ok_s) wr_ptr_s = wr_ptr_r + AW'(1); else wr_ptr_s = wr_ptr_r;
    if (pop_s)     rd_ptr_s = rd_ptr_r + AW'(1); else rd_ptr_s = rd_ptr_r;

    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase

    // A push landing on the new head slot bypasses the memory
    if (count_s != {CW{1'b0}}) begin
      if (push_ok_s && (wr_ptr_r == rd_ptr_s)) head_s = cap_r;
      else                                     head_s = mem_r[rd_ptr_s];
    end else begin
      head_s = evt_data_r;
    end

    if (drop_s)              overflow_s = 1'b1;
    else if (clear_overflow) overflow_s = 1'b0;
    else                     overflow_s = overflow_r;
  end

  // FIFO storage, pointers, registered head/valid and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      evt_data_r  <= '0;
      evt_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_ok_s) mem_r[wr_ptr_r] <= cap_r;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      evt_data_r  <= head_s;
      evt_valid_r <= (count_s != {CW{1'b0}});
      overflow_r  <= overflow_s;
    end
  end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: behavioural edge-capture PIO slave, table-driven
// single services, hand-written corner sequences and a randomized queue model.
module tb_pio_irq_servicer;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   m_address;
  logic         m_chipselect;
  logic         m_write_n;
  logic [31:0]  m_writedata;
  logic [31:0]  m_readdata;
  logic         irq;
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic         evt_ready;
  logic         overflow;
  logic         clear_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pio_irq_servicer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq(irq),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  // Slave model: mask reg at 2, edge capture at 3 (any write clears), registered readdata
  logic [31:0] s_mask;
  logic [W-1:0] s_edge;
  logic [W-1:0] inject;
  logic spur;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_mask     <= 32'd0;
      s_edge     <= '0;
      m_readdata <= 32'd0;
    end else begin
      if (m_chipselect && m_write_n)
        m_readdata <= (m_address == 2'd2) ? s_mask :
                      (m_address == 2'd3) ? {28'd0, s_edge} : 32'd0;
      if (m_chipselect && !m_write_n && m_address == 2'd2) s_mask <= m_writedata;
      if (m_chipselect && !m_write_n && m_address == 2'd3) s_edge <= '0;
      else s_edge <= s_edge | inject;
    end
  end

  assign irq = (|(s_edge & s_mask[W-1:0])) | spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full service of vector v, ending back in IDLE (cycle n+6)
  task automatic service(input logic [W-1:0] v);
    inject = v; step(); inject = '0;
    repeat (6) step();
  endtask

  task automatic pop_one();
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs"},    {31'd0, m_chipselect}, 32'd0);
    chk({tag, "_wn"},    {31'd0, m_write_n},    32'd1);
    chk({tag, "_addr"},  {30'd0, m_address},    32'd0);
    chk({tag, "_wdata"}, m_writedata,           32'd0);
    chk({tag, "_valid"}, {31'd0, evt_valid},    32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow},     32'd0);
  endtask

  // Observe the bus after reset release: exactly one access, the mask write
  task automatic check_init(input string tag);
    int n_cs = 0;
    logic [1:0]  wa = 2'd0;
    logic [31:0] wd = 32'd0;
    logic        wn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (m_chipselect) begin
        n_cs++;
        wa = m_address; wd = m_writedata; wn = m_write_n;
      end
    end
    chk({tag, "_access_count"}, n_cs, 32'd1);
    chk({tag, "_init_wn"},   {31'd0, wn}, 32'd0);
    chk({tag, "_init_addr"}, {30'd0, wa}, 32'd2);
    chk({tag, "_init_data"}, wd, 32'h0000_000F);
    chk({tag, "_slave_mask"}, s_mask, 32'h0000_000F);
    chk({tag, "_fifo_empty"}, {31'd0, evt_valid}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] vec;
    logic         spur;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[6];
  logic [W-1:0] exp_q[$];
  logic exp_ovf;

  initial begin
    reset_n = 1'b0; evt_ready = 1'b0; clear_overflow = 1'b0;
    inject = '0; spur = 1'b0;

    tbl[0] = '{4'b0100, 1'b0, 1'b1, 4'b0100};
    tbl[1] = '{4'b1000, 1'b0, 1'b1, 4'b1000};
    tbl[2] = '{4'b1111, 1'b0, 1'b1, 4'b1111};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[4] = '{4'b0011, 1'b0, 1'b1, 4'b0011};
    tbl[5] = '{4'b0001, 1'b0, 1'b1, 4'b0001};

    // Reset state and INIT mask write
    repeat (2) step();
    check_reset_vals("reset");
    reset_n = 1'b1;
    check_init("init");

    // Service latency for 4'b0100
    inject = 4'b0100; step(); inject = '0;              // cycle n
    step();                                             // n+1 READ
    chk("lat_read_cs",   {31'd0, m_chipselect}, 32'd1);
    chk("lat_read_wn",   {31'd0, m_write_n},    32'd1);
    chk("lat_read_addr", {30'd0, m_address},    32'd3);
    step();                                             // n+2 CAPTURE
    chk("lat_cap_idle",  {31'd0, m_chipselect}, 32'd0);
    step();                                             // n+3 CLEAR
    chk("lat_clr_cs",    {31'd0, m_chipselect}, 32'd1);
    chk("lat_clr_wn",    {31'd0, m_write_n},    32'd0);
    chk("lat_clr_addr",  {30'd0, m_address},    32'd3);
    chk("lat_clr_data",  m_writedata,           32'd0);
    step();                                             // n+4 PUSH
    chk("lat_push_valid", {31'd0, evt_valid}, 32'd0);
    step();                                             // n+5
    chk("lat_valid", {31'd0, evt_valid}, 32'd1);
    chk("lat_data",  {28'd0, evt_data},  32'h4);
    pop_one();
    chk("lat_popped", {31'd0, evt_valid}, 32'd0);
    step();

    // Table of single services, spurious irq included
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].spur) begin
        spur = 1'b1; step(); spur = 1'b0;
        repeat (5) step();
      end else begin
        service(tbl[i].vec);
      end
      chk($sformatf("tbl%0d_valid", i), {31'd0, evt_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_data", i), {28'd0, evt_data}, {28'd0, tbl[i].exp_data});
        pop_one();
      end
    end

    // Overflow: five services into a depth-4 FIFO
    for (int k = 1; k <= 5; k++) service(W'(k));
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d_valid", k), {31'd0, evt_valid}, 32'd1);
      chk($sformatf("ovf_pop%0d_data", k), {28'd0, evt_data}, k);
      pop_one();
    end
    chk("ovf_drained", {31'd0, evt_valid}, 32'd0);

    // Full FIFO with a pop in the PUSH cycle: no drop
    for (int k = 1; k <= 4; k++) service(W'(k));
    inject = 4'd5; step(); inject = '0;
    repeat (4) step();                                  // n+4 PUSH
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    step();
    chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("full_pp%0d_data", k), {28'd0, evt_data}, k);
      pop_one();
    end
    chk("full_pp_count4", {31'd0, evt_valid}, 32'd0);

    // Reset asserted during CLEAR with two events queued
    service(4'd1); service(4'd2);
    inject = 4'd3; step(); inject = '0;
    repeat (3) step();
    chk("rst_in_clear_wn", {31'd0, m_write_n}, 32'd0);
    reset_n = 1'b0; #1;
    check_reset_vals("async_rst");
    step(); step();
    reset_n = 1'b1;
    check_init("reinit");

    // Randomized bursts against a queue model
    for (int r = 0; r < 6; r++) begin
      int kk;
      int budget;
      exp_ovf = 1'b0;
      kk = int'($urandom_range(1, 7));
      for (int k = 0; k < kk; k++) begin
        logic [W-1:0] v;
        v = W'($urandom_range(1, 15));
        service(v);
        if (exp_q.size() < D) exp_q.push_back(v);
        else exp_ovf = 1'b1;
      end
      chk($sformatf("rnd%0d_ovf", r), {31'd0, overflow}, {31'd0, exp_ovf});
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
        logic rdy;
        logic vld;
        vld = evt_valid;
        chk($sformatf("rnd%0d_valid", r), {31'd0, vld}, 32'd1);
        if (vld) chk($sformatf("rnd%0d_data", r), {28'd0, evt_data}, {28'd0, exp_q[0]});
        rdy = 1'($urandom_range(0, 1));
        evt_ready = rdy; step(); evt_ready = 1'b0;
        if (rdy && vld) void'(exp_q.pop_front());
        budget++;
      end
      if (budget >= 200) chk($sformatf("rnd%0d_drain_timeout", r), 32'd1, 32'd0);
      chk($sformatf("rnd%0d_empty", r), {31'd0, evt_valid}, 32'd0);
      exp_q.delete();
      clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Avalon-MM initiator that services the 4-bit push-button edge-capture PIO slave in hardware, with no Nios software involved.
- After reset, programs the slave's interrupt mask once.
- On each irq, reads the edge-capture register, clears it with a write, and queues the captured bit-vector as an event in a small FWFT FIFO.
- Sits between the PIO slave's s1 port and downstream logic that consumes button events via valid/ready.

Parameters:
- WIDTH, 4, number of PIO input bits serviced (1..32).
- ADDR_MASK, 2, slave address of the irq mask register.
- ADDR_EDGE, 3, slave address of the edge-capture register.
- INIT_MASK, 4'hF, value written to the mask register after reset (WIDTH bits, zero-extended to 32).
- FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_address  out  2  slave address.
- m_chipselect  out  1  slave select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  slave read data, registered in the slave: value reflects the address presented on the previous cycle.
- irq  in  1  slave interrupt, combinational from edge_capture & irq_mask.
- evt_valid  out  1  event FIFO not empty.
- evt_data  out  WIDTH  head-of-FIFO edge vector.
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0, evt_valid=0, evt_data=0, overflow=0, FIFO empty, FSM=INIT.
- Bus idle default (every state without an access): chipselect=0, write_n=1, address=0, writedata=0. All bus outputs are registered.
- FSM states:
  - INIT: one cycle with chipselect=1, write_n=0, address=ADDR_MASK, writedata=INIT_MASK -> IDLE. Executed exactly once per reset.
  - IDLE: if irq=1 -> READ, else stay.
  - READ: one cycle with chipselect=1, write_n=1, address=ADDR_EDGE -> CAPTURE.
  - CAPTURE: latch cap = m_readdata[WIDTH-1:0]; bus idle -> CLEAR.
  - CLEAR: one cycle with chipselect=1, write_n=0, address=ADDR_EDGE, writedata=0 -> PUSH. The slave clears all capture bits at the end of this cycle.
  - PUSH: if cap != 0, push cap into the FIFO; if cap == 0 (spurious), push nothing -> HOLDOFF.
  - HOLDOFF: one idle cycle so irq settles low -> IDLE.
- Service latency: irq first high in IDLE at cycle n -> READ n+1, CAPTURE n+2, CLEAR n+3, PUSH n+4, evt_valid=1 at n+5 (FIFO previously empty). Minimum spacing between services is 6 cycles.
- Edges captured by the slave after READ but before the CLEAR edge are lost. This is a known, accepted limitation.
- Edges arriving after CLEAR re-raise irq and are serviced from IDLE.
- FIFO:
  - First-word-fall-through; evt_data = head; evt_valid = count != 0.
  - Pop on evt_valid & evt_ready.
  - Push when full is accepted only if a pop occurs in the same cycle; otherwise the event is dropped and overflow is set.
  - Simultaneous push and pop when not full: count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - evt_data is don't-care when evt_valid=0 but holds the last head value.
- overflow: set on a drop, cleared by clear_overflow. Set wins if both occur in the same cycle.
- irq held high continuously (mask nonzero, capture never clearing): the block loops through services every 6 cycles. No lockup.
- Reset mid-operation: all state returns to reset values immediately, the FIFO is emptied, and INIT reruns after reset deasserts.

Test Plan:
- Reset release -> exactly one write cycle (address=2, writedata=0x0000000F, write_n=0), then bus idle; no further bus activity while irq=0.
- irq raised at cycle n with slave capture=4'b0100 -> read of address 3 at n+1, write of address 3 at n+3, evt_valid=1 with evt_data=4'b0100 at n+5; evt_ready=1 -> evt_valid=0 next cycle.
- Five services of 4'b0001..4'b0101 with evt_ready=0 and depth 4 -> FIFO holds 1,2,3,4; fifth event dropped; overflow=1. clear_overflow pulse -> overflow=0. Pops yield 1,2,3,4 in order.
- FIFO full with PUSH and pop in the same cycle -> no drop, overflow stays 0, count remains 4, new tail = pushed value.
- Spurious irq with readdata=0 -> full read/clear sequence, no FIFO push, evt_valid unchanged.
- reset_n asserted during CLEAR with 2 events queued -> bus outputs and evt_valid go to reset values asynchronously; after release the INIT mask write repeats and the FIFO is empty.
